// File: rtl/photo_pkg.sv
// Shared definitions for the photo pulse conditioner: FSM state encoding and
// default build constants.
package photo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      LOST  = 2'd2
   } photo_state_t;

   localparam int FILT_LEN_DEF = 4;
   localparam int PERIOD_W_DEF = 21;
   localparam int TIMEOUT_DEF  = 1_000_000;

endpackage

// File: rtl/photo_glitch_filter.sv
// Two-flop synchronizer followed by a stability filter: the level only follows
// the synchronized input after FILT_LEN consecutive disagreeing samples.
module photo_glitch_filter
   import photo_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic level
);

   localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

   logic [1:0] sync_reg;
   logic [7:0] cnt_reg;
   logic       level_reg;

   // Pure synchronizer: nothing else may sit between these two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[0], in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         level_reg <= 1'b0;
      end else if (sync_reg[1] == level_reg) begin
         cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
         level_reg <= sync_reg[1];
         cnt_reg   <= '0;
      end else begin
         cnt_reg <= cnt_reg + 8'd1;
      end
   end

   assign level = level_reg;

endmodule

// File: rtl/photo_pulse_conditioner.sv
// Phototransistor front end: filtered level, rising-edge strobe and, when
// PHOTO_PERIOD_EN is defined, period measurement with loss-of-signal detection.
module photo_pulse_conditioner
   import photo_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF,
   parameter int PERIOD_W = PERIOD_W_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                JB0,
   output logic                level_o,
   output logic                pulse_o,
   output logic [PERIOD_W-1:0] period_o,
   output logic                period_valid_o,
   output logic                timeout_o
);

   generate
      if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt_len
         $error("photo_pulse_conditioner: FILT_LEN out of range 1..255");
      end
      if (64'(TIMEOUT) >= (64'd1 << PERIOD_W)) begin : g_bad_timeout
         $error("photo_pulse_conditioner: TIMEOUT does not fit in PERIOD_W bits");
      end
   endgenerate

   logic level;
   logic level_prev_reg;
   logic pulse;

   photo_glitch_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (JB0),
      .level (level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_prev_reg <= 1'b0;
      end else begin
         level_prev_reg <= level;
      end
   end

   // High during the first cycle the filtered level reads 1.
   assign pulse   = level & ~level_prev_reg;
   assign level_o = level;
   assign pulse_o = pulse;

`ifdef PHOTO_PERIOD_EN
   localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT);

   photo_state_t        state_reg;
   logic [PERIOD_W-1:0] elapsed_reg;
   logic [PERIOD_W-1:0] elapsed_next;
   logic [PERIOD_W-1:0] period_reg;
   logic                valid_reg;
   logic                timeout_reg;

   always_comb begin
      elapsed_next = elapsed_reg;
      if (pulse) begin
         elapsed_next = PERIOD_W'(1);
      end else if (elapsed_reg < TIMEOUT_CNT) begin
         elapsed_next = elapsed_reg + PERIOD_W'(1);
      end
   end

   // Timeout is flagged in the same cycle the counter shows TIMEOUT, so a
   // pulse arriving at that count is seen in LOST and only re-arms.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         elapsed_reg <= '0;
         period_reg  <= '0;
         valid_reg   <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         elapsed_reg <= elapsed_next;
         valid_reg   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pulse) state_reg <= ARMED;
            end
            ARMED: begin
               if (pulse) begin
                  if (elapsed_reg < TIMEOUT_CNT) begin
                     period_reg <= elapsed_reg;
                     valid_reg  <= 1'b1;
                  end
               end else if (elapsed_next == TIMEOUT_CNT) begin
                  state_reg   <= LOST;
                  timeout_reg <= 1'b1;
               end
            end
            LOST: begin
               if (pulse) begin
                  state_reg   <= ARMED;
                  timeout_reg <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign period_o       = period_reg;
   assign period_valid_o = valid_reg;
   assign timeout_o      = timeout_reg;
`else
   assign period_o       = '0;
   assign period_valid_o = 1'b0;
   assign timeout_o      = 1'b0;
`endif

endmodule

// File: doc/photo_pulse_conditioner.md
PHOTO_PULSE_CONDITIONER -- requirements
Module: photo_pulse_conditioner

Interface
REQ-001 SHALL have parameter FILT_LEN, default 4: consecutive stable samples needed before the filtered level changes (range 1..255).
REQ-002 SHALL have parameter PERIOD_W, default 21: width of the period measurement.
REQ-003 SHALL have parameter TIMEOUT, default 1_000_000: elapsed clocks without a pulse that declare loss of signal (must be < 2**PERIOD_W).
REQ-004 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port JB0  input  1  raw phototransistor signal, asynchronous to clk.
REQ-007 SHALL have port level_o  output  1  synchronized, glitch-filtered level.
REQ-008 SHALL have port pulse_o  output  1  one-clock strobe on each filtered rising edge, for the downstream frequency counter.
REQ-009 SHALL have port period_o  output  PERIOD_W  clocks between the last two strobes.
REQ-010 SHALL have port period_valid_o  output  1  one-clock strobe when period_o updates.
REQ-011 SHALL have port timeout_o  output  1  sticky loss-of-signal flag.

Function
REQ-012 SHALL synchronize JB0 through two flops; this path has no other logic.
REQ-013 SHALL change level_o only after the synchronized input differs from level_o for FILT_LEN consecutive clocks; any agreeing sample clears the stability count.
REQ-014 SHALL have a latency of 2+FILT_LEN clocks from a JB0 edge held stable to the matching level_o edge.
REQ-015 SHALL assert pulse_o for exactly the first clock in which level_o is 1 after being 0; falling edges produce no strobe.
REQ-016 SHALL implement the FSM IDLE -> ARMED on a pulse, ARMED -> ARMED on a pulse, ARMED -> LOST when elapsed reaches TIMEOUT, and LOST -> ARMED on a pulse.
REQ-017 SHALL clear the elapsed counter to 1 on each pulse and increment it once per clock otherwise, saturating at TIMEOUT.
REQ-018 SHALL, on a pulse in ARMED with elapsed < TIMEOUT, load period_o with elapsed and assert period_valid_o on the following clock.
REQ-019 SHALL, on a pulse in IDLE or LOST, produce no period_valid_o and hold period_o.
REQ-020 SHALL set timeout_o in the clock where elapsed reaches TIMEOUT in ARMED and clear it on the next pulse.
REQ-021 SHALL treat a pulse coinciding with elapsed == TIMEOUT as timeout followed by re-arm, with no valid strobe.
REQ-022 SHALL keep period_o stable between valid strobes.

Reset
REQ-023 SHALL, while rst_n is low, immediately drive sync flops, level_o, pulse_o, period_o, period_valid_o and timeout_o to 0, set the stability count to 0 and the FSM to IDLE.
REQ-024 SHALL make the first pulse after reset release arm the FSM only, with no period_valid_o.

Configuration
REQ-025 SHALL compile in the FSM, elapsed counter and period/timeout outputs when PHOTO_PERIOD_EN is defined.
REQ-026 SHALL, when PHOTO_PERIOD_EN is undefined, omit that logic and tie period_o, period_valid_o and timeout_o to constant 0; level_o and pulse_o are unchanged.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, ARMED, LOST) and the default FILT_LEN, PERIOD_W and TIMEOUT constants in shared package photo_pkg.
REQ-028 SHALL implement the synchronizer and filter as sub-module photo_glitch_filter (ports clk, rst_n, in, level), instantiated once.

Verification (FILT_LEN=4, TIMEOUT=1000, macro defined unless stated)
REQ-029 SHALL test that JB0 rising and held 20 clocks -> level_o rises 6 clocks later, pulse_o high exactly 1 clock.
REQ-030 SHALL test that a 3-clock high glitch on JB0 -> level_o stays 0, no pulse_o.
REQ-031 SHALL test that a JB0 square wave with period 100 clocks (50 high) -> no valid on the first strobe, then period_o=100 with period_valid_o on every later strobe.
REQ-032 SHALL test that after an armed strobe, no edge for 1000 clocks -> timeout_o set; next strobe clears it with no valid; the strobe after that gives a valid period.
REQ-033 SHALL test that rst_n pulsed low mid-measurement -> all outputs 0 asynchronously; first strobe after release gives no valid.
REQ-034 SHALL test that with PHOTO_PERIOD_EN undefined and the 100-clock square wave -> pulse_o toggles normally, period_o, period_valid_o and timeout_o stay 0.
